wb_stage: RTL and testbench

//   Writeback stage that drives the register file's single write port (wr_reg/wr_value/wr_enable).

---
 rtl/tinyarch_pkg.sv | 17 +
 rtl/wb_fifo.sv | 50 +++++
 rtl/wb_stage.sv | 134 +++++++++++++
 tb/tb_wb_stage.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/tinyarch_pkg.sv
// Shared register-file geometry and writeback request type.
// No logic; types and constants only.
// No flow control.
package tinyarch_pkg;
    localparam int REG_ADDR_WIDTH = 4;
    localparam int REG_WIDTH      = 8;
    localparam int NUM_REGS       = 2**REG_ADDR_WIDTH;

    // Slot 15 writes land in the register named by reg 14.
    localparam logic [REG_ADDR_WIDTH-1:0] ACC_PTR_REG = 4'd14;
    localparam logic [REG_ADDR_WIDTH-1:0] ACC_IND_REG = 4'd15;

    typedef struct packed {
        logic [REG_ADDR_WIDTH-1:0] rd;
        logic [REG_WIDTH-1:0]      data;
    } wb_req_t;
endpackage

// File: rtl/wb_fifo.sv
// Synchronous FIFO of writeback requests.
// Latency: push visible at head the cycle after; head is read combinationally.
// Backpressure: push ignored while full, pop ignored while empty.
module wb_fifo
    import tinyarch_pkg::*;
#(
    parameter int DEPTH = 2
) (
    input  logic    clk,
    input  logic    rst_n,
    input  logic    push,
    input  wb_req_t push_dat,
    input  logic    pop,
    output wb_req_t pop_dat,
    output logic    full,
    output logic    empty
);
    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    wb_req_t        mem [DEPTH];
    logic [AW-1:0]  wr_ptr;
    logic [AW-1:0]  rd_ptr;
    logic [CW-1:0]  count;
    logic           do_push;
    logic           do_pop;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign pop_dat = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= (wr_ptr == AW'(DEPTH - 1)) ? '0 : wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= (rd_ptr == AW'(DEPTH - 1)) ? '0 : rd_ptr + AW'(1);
            count <= count + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset; occupancy is tracked by count.
    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= push_dat;
    end
endmodule

// File: rtl/wb_stage.sv
// Writeback: merges ALU and load-return streams onto the regfile write port, tracks pending writes.
// Latency: ALU 1 cycle, loads >=2 cycles via FIFO; optional WB_BYPASS_EN exposes next-cycle write.
// Backpressure: ALU never stalled (wins arbitration); ld_ready = !fifo_full; issue_ready = counter not saturated.
module wb_stage
    import tinyarch_pkg::*;
#(
    parameter int LD_FIFO_DEPTH = 2,
    parameter int PEND_W        = 2
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      issue_valid,
    input  logic [REG_ADDR_WIDTH-1:0] issue_reg,
    output logic                      issue_ready,
    input  logic                      alu_valid,
    input  logic [REG_ADDR_WIDTH-1:0] alu_reg,
    input  logic [REG_WIDTH-1:0]      alu_data,
    input  logic                      ld_valid,
    input  logic [REG_ADDR_WIDTH-1:0] ld_reg,
    input  logic [REG_WIDTH-1:0]      ld_data,
    output logic                      ld_ready,
    output logic                      wr_enable,
    output logic [REG_ADDR_WIDTH-1:0] wr_reg,
    output logic [REG_WIDTH-1:0]      wr_value,
    output logic [NUM_REGS-1:0]       pending_mask,
    output logic                      sb_err
`ifdef WB_BYPASS_EN
    ,
    output logic                      byp_valid,
    output logic [REG_ADDR_WIDTH-1:0] byp_reg,
    output logic [REG_WIDTH-1:0]      byp_value
`endif
);
    localparam logic [PEND_W-1:0] CNT_MAX = '1;

    wb_req_t                   ld_req;
    wb_req_t                   fifo_head;
    logic                      fifo_full;
    logic                      fifo_empty;
    logic                      ld_push;
    logic                      fifo_pop;
    logic                      nxt_en;
    logic [REG_ADDR_WIDTH-1:0] nxt_reg;
    logic [REG_WIDTH-1:0]      nxt_value;
    logic [PEND_W-1:0]         pend_cnt [NUM_REGS];
    logic                      issue_fire;
    logic [NUM_REGS-1:0]       inc_vec;
    logic [NUM_REGS-1:0]       dec_vec;

    assign ld_req   = '{rd: ld_reg, data: ld_data};
    assign ld_ready = rst_n && !fifo_full;
    assign ld_push  = ld_valid && ld_ready;
    assign fifo_pop = rst_n && !alu_valid && !fifo_empty;

    wb_fifo #(.DEPTH(LD_FIFO_DEPTH)) u_ld_fifo (
        .clk      (clk),
        .rst_n    (rst_n),
        .push     (ld_push),
        .push_dat (ld_req),
        .pop      (fifo_pop),
        .pop_dat  (fifo_head),
        .full     (fifo_full),
        .empty    (fifo_empty)
    );

    // ALU has strict priority; loads drain only in ALU-idle cycles.
    always_comb begin
        nxt_en    = 1'b0;
        nxt_reg   = wr_reg;
        nxt_value = wr_value;
        if (alu_valid) begin
            nxt_en    = 1'b1;
            nxt_reg   = alu_reg;
            nxt_value = alu_data;
        end else if (!fifo_empty) begin
            nxt_en    = 1'b1;
            nxt_reg   = fifo_head.rd;
            nxt_value = fifo_head.data;
        end
    end

`ifdef WB_BYPASS_EN
    assign byp_valid = nxt_en;
    assign byp_reg   = nxt_reg;
    assign byp_value = nxt_value;
`endif

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_enable <= 1'b0;
            wr_reg    <= '0;
            wr_value  <= '0;
        end else begin
            wr_enable <= nxt_en;
            wr_reg    <= nxt_reg;
            wr_value  <= nxt_value;
        end
    end

    assign issue_ready = (pend_cnt[issue_reg] != CNT_MAX);
    assign issue_fire  = issue_valid && issue_ready;

    always_comb begin
        inc_vec = '0;
        dec_vec = '0;
        for (int i = 0; i < NUM_REGS; i++) begin
            inc_vec[i] = issue_fire && (issue_reg == REG_ADDR_WIDTH'(i));
            dec_vec[i] = wr_enable && (wr_reg == REG_ADDR_WIDTH'(i));
        end
    end

    // A same-cycle issue and retire on one register cancel out.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) pend_cnt[i] <= '0;
            sb_err <= 1'b0;
        end else begin
            if (wr_enable && pend_cnt[wr_reg] == '0) sb_err <= 1'b1;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (inc_vec[i] && !dec_vec[i])
                    pend_cnt[i] <= pend_cnt[i] + PEND_W'(1);
                else if (dec_vec[i] && !inc_vec[i] && pend_cnt[i] != '0)
                    pend_cnt[i] <= pend_cnt[i] - PEND_W'(1);
            end
        end
    end

    // A pending indirect write may hit any register, so stall everything.
    always_comb begin
        pending_mask = '0;
        for (int i = 0; i < NUM_REGS; i++) pending_mask[i] = (pend_cnt[i] != '0);
        if (pend_cnt[ACC_IND_REG] != '0) pending_mask = '1;
    end
endmodule

// File: tb/tb_wb_stage.sv
// Bench for wb_stage: directed scenarios plus a randomized run against a queue/array reference model.
module tb_wb_stage;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       issue_valid;
    logic [3:0] issue_reg;
    logic       issue_ready;
    logic       alu_valid;
    logic [3:0] alu_reg;
    logic [7:0] alu_data;
    logic       ld_valid;
    logic [3:0] ld_reg;
    logic [7:0] ld_data;
    logic       ld_ready;
    logic       wr_enable;
    logic [3:0] wr_reg;
    logic [7:0] wr_value;
    logic [15:0] pending_mask;
    logic       sb_err;

    int n_pass  = 0;
    int n_total = 0;

    // Reference model state
    logic [11:0] m_q [$];
    int          m_cnt [16];
    bit          m_err;
    bit          m_wen;
    logic [3:0]  m_wreg;
    logic [7:0]  m_wval;

    wb_stage dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .issue_valid  (issue_valid),
        .issue_reg    (issue_reg),
        .issue_ready  (issue_ready),
        .alu_valid    (alu_valid),
        .alu_reg      (alu_reg),
        .alu_data     (alu_data),
        .ld_valid     (ld_valid),
        .ld_reg       (ld_reg),
        .ld_data      (ld_data),
        .ld_ready     (ld_ready),
        .wr_enable    (wr_enable),
        .wr_reg       (wr_reg),
        .wr_value     (wr_value),
        .pending_mask (pending_mask),
        .sb_err       (sb_err)
    );

    always #5 clk = ~clk;

    function automatic logic [15:0] model_mask();
        logic [15:0] m;
        m = '0;
        for (int i = 0; i < 16; i++) m[i] = (m_cnt[i] != 0);
        if (m_cnt[15] != 0) m = 16'hFFFF;
        return m;
    endfunction

    function automatic bit model_issue_ready();
        return m_cnt[issue_reg] < 3;
    endfunction

    function automatic bit model_ld_ready();
        return rst_n && (m_q.size() < 2);
    endfunction

    task automatic idle_inputs();
        issue_valid = 0; issue_reg = 0;
        alu_valid = 0; alu_reg = 0; alu_data = 0;
        ld_valid = 0; ld_reg = 0; ld_data = 0;
    endtask

    // Advance model from current inputs, then clock the DUT and settle.
    task automatic tick();
        bit          issue_ok, same, push;
        logic [11:0] e;
        if (!rst_n) begin
            m_q.delete();
            for (int i = 0; i < 16; i++) m_cnt[i] = 0;
            m_err = 0; m_wen = 0; m_wreg = 0; m_wval = 0;
        end else begin
            issue_ok = issue_valid && (m_cnt[issue_reg] < 3);
            same     = issue_ok && m_wen && (issue_reg == m_wreg);
            if (m_wen && m_cnt[m_wreg] == 0) m_err = 1;
            if (!same) begin
                if (m_wen && m_cnt[m_wreg] > 0) m_cnt[m_wreg] = m_cnt[m_wreg] - 1;
                if (issue_ok) m_cnt[issue_reg] = m_cnt[issue_reg] + 1;
            end
            push = ld_valid && (m_q.size() < 2);
            if (alu_valid) begin
                m_wen = 1; m_wreg = alu_reg; m_wval = alu_data;
            end else if (m_q.size() > 0) begin
                e = m_q.pop_front();
                m_wen = 1; m_wreg = e[11:8]; m_wval = e[7:0];
            end else begin
                m_wen = 0;
            end
            if (push) m_q.push_back({ld_reg, ld_data});
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 0;
        idle_inputs();
        #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL reset_ld_ready got %0b exp 0", ld_ready); else n_pass++;
        tick(); tick();
        n_total++; if (wr_enable !== 1'b0) $display("FAIL reset_wr_enable got %0b exp 0", wr_enable); else n_pass++;
        n_total++; if (wr_reg !== 4'd0 || wr_value !== 8'd0) $display("FAIL reset_wr got %0d/%0h exp 0/0", wr_reg, wr_value); else n_pass++;
        n_total++; if (sb_err !== 1'b0 || pending_mask !== 16'h0) $display("FAIL reset_sb got err %0b mask %h exp 0 0000", sb_err, pending_mask); else n_pass++;
        rst_n = 1;
        #1;
        n_total++; if (ld_ready !== 1'b1) $display("FAIL post_reset_ld_ready got %0b exp 1", ld_ready); else n_pass++;
    endtask

    task automatic test_alu_basic();
        issue_valid = 1; issue_reg = 3;
        alu_valid = 1; alu_reg = 3; alu_data = 8'h5A;
        tick();
        idle_inputs();
        n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd3 || wr_value !== 8'h5A)
            $display("FAIL alu_basic got en %0b reg %0d val %h exp 1 3 5a", wr_enable, wr_reg, wr_value); else n_pass++;
        n_total++; if (pending_mask !== 16'h0008) $display("FAIL alu_basic_mask got %h exp 0008", pending_mask); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b0 || wr_reg !== 4'd3 || wr_value !== 8'h5A)
            $display("FAIL alu_basic_idle got en %0b reg %0d val %h exp 0 3 5a", wr_enable, wr_reg, wr_value); else n_pass++;
        n_total++; if (pending_mask !== 16'h0 || sb_err !== 1'b0)
            $display("FAIL alu_basic_retire got mask %h err %0b exp 0000 0", pending_mask, sb_err); else n_pass++;
    endtask

    task automatic test_alu_vs_load();
        alu_valid = 1; alu_reg = 5; alu_data = 8'h22;
        ld_valid = 1; ld_reg = 4; ld_data = 8'h11;
        tick();
        idle_inputs();
        n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd5 || wr_value !== 8'h22)
            $display("FAIL arb_alu got en %0b reg %0d val %h exp 1 5 22", wr_enable, wr_reg, wr_value); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd4 || wr_value !== 8'h11)
            $display("FAIL arb_load got en %0b reg %0d val %h exp 1 4 11", wr_enable, wr_reg, wr_value); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b0) $display("FAIL arb_idle got %0b exp 0", wr_enable); else n_pass++;
    endtask

    task automatic test_starvation();
        for (int c = 0; c < 5; c++) begin
            alu_valid = 1; alu_reg = 1; alu_data = 8'h30 + 8'(c);
            ld_valid = (c < 3); ld_reg = 4'(8 + c); ld_data = 8'hA0 + 8'(c);
            #1;
            n_total++; if (ld_ready !== (c < 2)) $display("FAIL starve_ld_ready c%0d got %0b exp %0b", c, ld_ready, c < 2); else n_pass++;
            tick();
            n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd1 || wr_value !== 8'h30 + 8'(c))
                $display("FAIL starve_alu c%0d got reg %0d val %h exp 1 %h", c, wr_reg, wr_value, 8'h30 + 8'(c)); else n_pass++;
        end
        idle_inputs();
        tick();
        n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd8 || wr_value !== 8'hA0)
            $display("FAIL starve_ld0 got en %0b reg %0d val %h exp 1 8 a0", wr_enable, wr_reg, wr_value); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b1 || wr_reg !== 4'd9 || wr_value !== 8'hA1)
            $display("FAIL starve_ld1 got en %0b reg %0d val %h exp 1 9 a1", wr_enable, wr_reg, wr_value); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b0) $display("FAIL starve_drained got %0b exp 0", wr_enable); else n_pass++;
    endtask

    task automatic test_issue_saturate();
        for (int k = 0; k < 3; k++) begin
            issue_valid = 1; issue_reg = 7;
            tick();
        end
        #1;
        n_total++; if (issue_ready !== 1'b0) $display("FAIL sat_issue_ready got %0b exp 0", issue_ready); else n_pass++;
        tick();
        idle_inputs();
        n_total++; if (pending_mask[7] !== 1'b1) $display("FAIL sat_mask7 got %0b exp 1", pending_mask[7]); else n_pass++;
        for (int k = 0; k < 3; k++) begin
            alu_valid = 1; alu_reg = 7; alu_data = 8'(k);
            tick();
        end
        idle_inputs();
        n_total++; if (pending_mask[7] !== 1'b1) $display("FAIL sat_mask7_mid got %0b exp 1", pending_mask[7]); else n_pass++;
        tick();
        issue_reg = 7;
        #1;
        n_total++; if (pending_mask[7] !== 1'b0 || issue_ready !== 1'b1)
            $display("FAIL sat_drained got mask7 %0b ready %0b exp 0 1", pending_mask[7], issue_ready); else n_pass++;
        n_total++; if (sb_err !== m_err) $display("FAIL sat_sb_err got %0b exp %0b", sb_err, m_err); else n_pass++;
    endtask

    task automatic test_indirect();
        issue_valid = 1; issue_reg = 2;
        tick();
        issue_reg = 15;
        tick();
        idle_inputs();
        n_total++; if (pending_mask !== 16'hFFFF) $display("FAIL ind_all got %h exp ffff", pending_mask); else n_pass++;
        alu_valid = 1; alu_reg = 15; alu_data = 8'h77;
        tick();
        idle_inputs();
        n_total++; if (wr_reg !== 4'd15 || pending_mask !== 16'hFFFF)
            $display("FAIL ind_write got reg %0d mask %h exp 15 ffff", wr_reg, pending_mask); else n_pass++;
        tick();
        n_total++; if (pending_mask !== 16'h0004) $display("FAIL ind_retired got %h exp 0004", pending_mask); else n_pass++;
        alu_valid = 1; alu_reg = 2; alu_data = 8'h02;
        tick();
        idle_inputs();
        tick();
        n_total++; if (pending_mask !== 16'h0000) $display("FAIL ind_clear got %h exp 0000", pending_mask); else n_pass++;
    endtask

    task automatic test_sb_err_and_reset();
        rst_n = 0;
        tick();
        rst_n = 1;
        n_total++; if (sb_err !== 1'b0) $display("FAIL sb_pre got %0b exp 0", sb_err); else n_pass++;
        alu_valid = 1; alu_reg = 2; alu_data = 8'h99;
        tick();
        idle_inputs();
        tick(); tick(); tick();
        n_total++; if (sb_err !== 1'b1 || pending_mask[2] !== 1'b0)
            $display("FAIL sb_sticky got err %0b mask2 %0b exp 1 0", sb_err, pending_mask[2]); else n_pass++;
        for (int k = 0; k < 2; k++) begin
            alu_valid = 1; alu_reg = 1; alu_data = 8'h10;
            ld_valid = 1; ld_reg = 6; ld_data = 8'h66;
            tick();
        end
        rst_n = 0;
        alu_valid = 0;
        #1;
        n_total++; if (ld_ready !== 1'b0) $display("FAIL rst_ld_ready got %0b exp 0", ld_ready); else n_pass++;
        tick();
        n_total++; if (wr_enable !== 1'b0 || wr_reg !== 4'd0 || wr_value !== 8'd0 || sb_err !== 1'b0)
            $display("FAIL rst_mid got en %0b reg %0d val %h err %0b exp 0 0 0 0", wr_enable, wr_reg, wr_value, sb_err); else n_pass++;
        rst_n = 1;
        idle_inputs();
        tick();
        n_total++; if (wr_enable !== 1'b0) $display("FAIL rst_fifo_empty got %0b exp 0", wr_enable); else n_pass++;
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            rst_n       = ($urandom_range(0, 63) != 0);
            issue_valid = $urandom_range(0, 1);
            issue_reg   = 4'($urandom_range(0, 15));
            alu_valid   = ($urandom_range(0, 2) == 0);
            alu_reg     = 4'($urandom_range(0, 15));
            alu_data    = 8'($urandom);
            ld_valid    = $urandom_range(0, 1);
            ld_reg      = 4'($urandom_range(0, 15));
            ld_data     = 8'($urandom);
            #1;
            n_total++; if (ld_ready !== model_ld_ready()) $display("FAIL rnd_ld_ready c%0d got %0b exp %0b", c, ld_ready, model_ld_ready()); else n_pass++;
            if (rst_n) begin
                n_total++; if (issue_ready !== model_issue_ready()) $display("FAIL rnd_issue_ready c%0d got %0b exp %0b", c, issue_ready, model_issue_ready()); else n_pass++;
            end
            tick();
            n_total++; if (wr_enable !== m_wen || wr_reg !== m_wreg || wr_value !== m_wval)
                $display("FAIL rnd_wr c%0d got %0b/%0d/%h exp %0b/%0d/%h", c, wr_enable, wr_reg, wr_value, m_wen, m_wreg, m_wval); else n_pass++;
            n_total++; if (pending_mask !== model_mask() || sb_err !== m_err)
                $display("FAIL rnd_sb c%0d got %h/%0b exp %h/%0b", c, pending_mask, sb_err, model_mask(), m_err); else n_pass++;
        end
        rst_n = 1;
        idle_inputs();
    endtask

    initial begin
        test_reset();
        test_alu_basic();
        test_alu_vs_load();
        test_starvation();
        test_issue_saturate();
        test_indirect();
        test_sb_err_and_reset();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
